mem_port_arbiter: RTL and testbench

//   Shares one single-ported unified memory between the CPU instruction-fetch port and its data port.

---
 rtl/arb_pkg.sv | 36 +++
 rtl/mem_arb_prio.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Purpose: shared types and constants for the unified-memory port arbiter.
//   state_t   - arbiter FSM states
//   owner_t   - which requester owns the in-flight transaction
//   mem_cmd_t - latched memory command payload
package arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 3;

  // memsize encoding shared with the core
  localparam logic [SIZE_W-1:0] MEMSIZE_BYTE = 3'd0;
  localparam logic [SIZE_W-1:0] MEMSIZE_HALF = 3'd1;
  localparam logic [SIZE_W-1:0] MEMSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Purpose: grant selection between fetch and data ports with a starvation
//   guard: data normally wins, but after STREAK consecutive data grants with
//   a fetch waiting, the fetch is granted once.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   if_req, d_req   - raw requests from fetch and data ports
//   en              - arbiter is idle and may grant this cycle
//   gnt_if, gnt_d   - one-hot grant (combinational, only while en)
module mem_arb_prio #(
  parameter int unsigned STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic en,
  output logic gnt_if,
  output logic gnt_d
);

  localparam int unsigned CNT_W = $clog2(STREAK + 1);

  logic [CNT_W-1:0] streak;
  logic             force_if;

  assign force_if = if_req && (streak == CNT_W'(STREAK));
  assign gnt_if   = en && if_req && (force_if || !d_req);
  assign gnt_d    = en && d_req && !force_if;

  // Count data grants that bypassed a waiting fetch; saturate at STREAK.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (gnt_if) begin
      streak <= '0;
    end else if (gnt_d) begin
      if (!if_req) begin
        streak <= '0;
      end else if (streak != CNT_W'(STREAK)) begin
        streak <= streak + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between the instruction-fetch and
//   data ports. One transaction at a time: grant, issue, wait for read data,
//   return it to the owner through a register.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   if_req/if_addr, if_gnt              - fetch request and grant pulse
//   if_rvalid/if_rdata                  - fetch response
//   d_req/d_we/d_size/d_addr/d_wdata    - data request, d_gnt grant pulse
//   d_rvalid/d_rdata                    - load response (none for stores)
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata - memory command (1-cycle)
//   mem_rvalid/mem_rdata                - memory read response
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [SIZE_W-1:0] d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_n;
  owner_t            owner, owner_n;
  mem_cmd_t          cmd, cmd_n;
  logic              en, gnt_if, gnt_d;
  logic              mem_req_n, mem_we_n;
  logic              if_rvalid_n, d_rvalid_n;
  logic [DATA_W-1:0] if_rdata_n, d_rdata_n;

  // Grants only in IDLE and never while reset is asserted.
  assign en = (state == IDLE) && !reset;

  mem_arb_prio #(.STREAK(STREAK)) u_prio (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .en     (en),
    .gnt_if (gnt_if),
    .gnt_d  (gnt_d)
  );

  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;
  assign mem_size  = cmd.size;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= NONE;
      cmd       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      cmd       <= cmd_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      if_rvalid <= if_rvalid_n;
      d_rvalid  <= d_rvalid_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_if || gnt_d) state_n = ISSUE;
      ISSUE:   state_n = cmd.we ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs and command/response latches.
  always_comb begin
    owner_n     = owner;
    cmd_n       = cmd;
    mem_req_n   = 1'b0;
    mem_we_n    = 1'b0;
    if_rvalid_n = 1'b0;
    d_rvalid_n  = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;

    if (gnt_if) begin
      owner_n       = FETCH;
      cmd_n.we      = 1'b0;
      cmd_n.size    = MEMSIZE_WORD;
      cmd_n.addr    = if_addr;
      cmd_n.wdata   = '0;
      mem_req_n     = 1'b1;
    end else if (gnt_d) begin
      owner_n       = DATA;
      cmd_n.we      = d_we;
      cmd_n.size    = d_size;
      cmd_n.addr    = d_addr;
      cmd_n.wdata   = d_wdata;
      mem_req_n     = 1'b1;
      mem_we_n      = d_we;
    end

    // Stores complete at issue; no response is owed.
    if (state == ISSUE && cmd.we) owner_n = NONE;

    // Read data is captured here and presented one cycle later in RESP.
    if (state == WAIT && mem_rvalid) begin
      if (owner == FETCH) begin
        if_rvalid_n = 1'b1;
        if_rdata_n  = mem_rdata;
      end else if (owner == DATA) begin
        d_rvalid_n = 1'b1;
        d_rdata_n  = mem_rdata;
      end
    end

    if (state == RESP) owner_n = NONE;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: read data returns 'lat' cycles after mem_req.
  int          lat    = 1;
  int          cnt    = 0;
  logic [31:0] rd_val = 32'h0;
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_val;
      end
    end
    if (mem_req && !mem_we) cnt = lat;
  end

  // Event monitor over the whole run.
  int n_if_gnt = 0, n_d_gnt = 0, n_both = 0, n_if_rv = 0, n_d_rv = 0;
  always @(posedge clk) begin
    if (if_gnt) n_if_gnt++;
    if (d_gnt) n_d_gnt++;
    if (if_gnt && d_gnt) n_both++;
    if (if_rvalid) n_if_rv++;
    if (d_rvalid) n_d_rv++;
  end

  typedef struct {
    logic        fetch;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [2:0]  exp_size;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  function automatic vec_t mk(logic f, logic w, logic [2:0] s, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, int l, logic [2:0] es);
    vec_t v;
    v.fetch = f; v.we = w; v.size = s; v.addr = a;
    v.wdata = wd; v.rdata = rd; v.lat = l; v.exp_size = es;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t        v;
  logic        bad;
  int          ngr, cyc;
  logic [9:0]  exp_f;

  initial begin
    vecs[0] = mk(1'b1, 1'b0, MEMSIZE_BYTE, 32'h0000_0100, 32'h0, 32'h0050_0093, 1,  MEMSIZE_WORD);
    vecs[1] = mk(1'b0, 1'b1, MEMSIZE_BYTE, 32'h0000_2003, 32'hAB, 32'h0,       1,  MEMSIZE_BYTE);
    vecs[2] = mk(1'b0, 1'b0, MEMSIZE_WORD, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 1, MEMSIZE_WORD);
    vecs[3] = mk(1'b0, 1'b0, MEMSIZE_HALF, 32'h0000_3002, 32'h0, 32'h0000_1234, 5, MEMSIZE_HALF);
    vecs[4] = mk(1'b0, 1'b0, MEMSIZE_BYTE, 32'h0000_3005, 32'h0, 32'h0000_00A5, 17, MEMSIZE_BYTE);
    vecs[5] = mk(1'b0, 1'b1, MEMSIZE_WORD, 32'h0000_4000, 32'h1122_3344, 32'h0, 1, MEMSIZE_WORD);
    vecs[6] = mk(1'b1, 1'b0, MEMSIZE_HALF, 32'h0000_0104, 32'h0, 32'h0000_0013, 3, MEMSIZE_WORD);

    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset ctrl", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we}), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    reset = 1'b0;

    // Reset mid-WAIT aborts the load; the late memory response is ignored.
    @(negedge clk);
    lat = 20; rd_val = 32'h5555_AAAA;
    d_req = 1'b1; d_we = 1'b0; d_size = MEMSIZE_WORD; d_addr = 32'h0000_5000;
    #1 chk("rst load gnt", 32'(d_gnt), 32'h1);
    @(negedge clk);
    chk("rst load mem_req", 32'(mem_req), 32'h1);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midwait reset ctrl", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we}), 32'h0);
    chk("midwait reset mem_addr", mem_addr, 32'h0);
    chk("midwait reset mem_size", 32'(mem_size), 32'h0);
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (if_rvalid || d_rvalid || mem_req || if_gnt || d_gnt) bad = 1'b1;
    end
    chk("late rvalid after reset", 32'(bad), 32'h0);

    // Table-driven single transactions.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      lat = v.lat; rd_val = v.rdata;
      d_size = v.size;
      if (v.fetch) begin
        if_req = 1'b1; if_addr = v.addr;
      end else begin
        d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end
      #1 chk($sformatf("v%0d gnt", i), 32'({if_gnt, d_gnt}), 32'({v.fetch, !v.fetch}));
      @(negedge clk);
      chk($sformatf("v%0d mem_req/we", i), 32'({mem_req, mem_we}), 32'({1'b1, v.we}));
      chk($sformatf("v%0d mem_addr", i), mem_addr, v.addr);
      chk($sformatf("v%0d mem_size", i), 32'(mem_size), 32'(v.exp_size));
      chk($sformatf("v%0d gnt in issue", i), 32'({if_gnt, d_gnt}), 32'h0);
      if (v.we) begin
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
        d_req = 1'b0;
      end else begin
        bad = 1'b0;
        for (int k = 2; k <= v.lat + 1; k++) begin
          @(negedge clk);
          if (if_rvalid || d_rvalid || if_gnt || d_gnt || mem_req) bad = 1'b1;
        end
        chk($sformatf("v%0d quiet in wait", i), 32'(bad), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d rvalid", i), 32'({if_rvalid, d_rvalid, if_gnt, d_gnt}),
            32'({v.fetch, !v.fetch, 2'b00}));
        chk($sformatf("v%0d rdata", i), v.fetch ? if_rdata : d_rdata, v.rdata);
        if_req = 1'b0; d_req = 1'b0;
      end
    end

    // Contention: both held, expect DDDDF DDDDF.
    @(negedge clk);
    @(negedge clk);
    lat = 2; rd_val = 32'hC0FF_EE00;
    d_we = 1'b0; d_size = MEMSIZE_WORD; d_addr = 32'h0000_6000; if_addr = 32'h0000_0200;
    if_req = 1'b1; d_req = 1'b1;
    exp_f = 10'b10_0001_0000;
    ngr = 0; cyc = 0;
    while (ngr < 10 && cyc < 300) begin
      #1;
      if (if_gnt || d_gnt) begin
        chk($sformatf("contention grant %0d is fetch", ngr), 32'(if_gnt), 32'(exp_f[ngr]));
        ngr++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("contention grant count", 32'(ngr), 32'd10);
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clk);

    // Fetch request withdrawn while a load sits in WAIT.
    lat = 6; rd_val = 32'h0BAD_F00D;
    d_req = 1'b1; d_we = 1'b0; d_size = MEMSIZE_WORD; d_addr = 32'h0000_7000;
    #1 chk("withdraw load gnt", 32'(d_gnt), 32'h1);
    @(negedge clk);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0300;
    #1 chk("withdraw no if_gnt", 32'(if_gnt), 32'h0);
    @(negedge clk);
    if_req = 1'b0;
    bad = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      if (if_gnt || d_gnt || mem_req || d_rvalid) bad = 1'b1;
    end
    chk("withdraw quiet in wait", 32'(bad), 32'h0);
    @(negedge clk);
    chk("withdraw d_rvalid", 32'({if_rvalid, d_rvalid}), 32'h1);
    chk("withdraw d_rdata", d_rdata, 32'h0BAD_F00D);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if_gnt || mem_req || if_rvalid) bad = 1'b1;
    end
    chk("withdraw no fetch issued", 32'(bad), 32'h0);

    chk("total if_gnt", 32'(n_if_gnt), 32'd4);
    chk("total d_gnt", 32'(n_d_gnt), 32'd15);
    chk("double grants", 32'(n_both), 32'd0);
    chk("total if_rvalid", 32'(n_if_rv), 32'd4);
    chk("total d_rvalid", 32'(n_d_rv), 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
